register_write_arbiter: RTL
===========================

// Module: register_write_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the shared 32-bit per-bit-enable register (en/d/q, 32 x 1-bit cells).
//  Up to N requesters each submit one masked operation (WRITE/SET/CLR/TOGGLE) per valid/ready handshake.
//  Drives the register's en/d inputs for exactly one cycle per accepted op.
//  Interlocks read-modify-write (TOGGLE) against writes still in flight.
// PARAMETERS
//  N      4   number of requesters (2..8)
//  IDX_W  2   owner index width, $clog2(N)
// PORTS
//  clk_i        in   1      single clock, rising edge
//  rst_i        in   1      reset, asynchronous, active-high
//  req_valid_i  in   N      request valid, one bit per requester
//  req_op_i     in   2*N    op per requester [2k+1:2k]: 00 WRITE, 01 SET, 10 CLR, 11 TOGGLE
//  req_mask_i   in   32*N   bit mask per requester [32k+31:32k]
//  req_data_i   in   32*N   write data per requester (used by WRITE only)
//  req_ready_o  out  N      one-hot accept; valid & ready = transfer
//  q_i          in   32     current register contents (q_o of the register)
//  en_o         out  32     per-bit enable to register
//  d_o          out  32     data to register
//  busy_o       out  1      write slot active this cycle
//  owner_o      out  IDX_W  index of requester owning the current slot
// BEHAVIOUR
//  Clock and reset: one clock domain; reset is asynchronous and active-high.
//  Reset values: en_o=0, d_o=0, busy_o=0, owner_o=0, rr_ptr=0, hazard_q=0.
//    req_ready_o is all zero while rst_i is high.
//  Arbitration:
//    - Combinational search from rr_ptr upward, wrapping modulo N; first k with req_valid_i[k]=1 is the candidate.
//    - req_ready_o[k]=1 for the candidate only; at most one bit set.
//    - On acceptance of k: rr_ptr <= (k+1) mod N. No acceptance: rr_ptr holds.
//  Hazard interlock:
//    - hazard_q <= 1 in the cycle after any acceptance, else 0.
//    - If hazard_q=1 and the candidate op is TOGGLE: no ready asserted that cycle; rr_ptr holds (one-cycle bubble).
//    - WRITE/SET/CLR are never stalled.
//  Slot timing: acceptance in cycle t drives registered outputs for cycle t+1 only.
//    - Cycle t+1: busy_o=1, owner_o=k, en_o=mask_k.
//    - Cycle t+2: register holds the new value and q_i reflects it; back-to-back accepts give one slot per cycle.
//  d_o by op, computed in cycle t:
//    - WRITE: d = data_k
//    - SET: d = 32'hFFFF_FFFF
//    - CLR: d = 0
//    - TOGGLE: d = ~q_i (sampled in cycle t)
//  Slot end: en_o returns to 0 and busy_o to 0 in any cycle with no preceding acceptance.
//    d_o and owner_o hold their last values.
//  mask=0: still accepted, consumes a slot (busy_o=1, en_o=0); register unchanged.
//  Requesters hold op/mask/data stable while valid & !ready; valid never retracts before ready.
//    The arbiter does not check this.
//  Reset mid-operation: en_o clears immediately (async), so no partial write occurs at the next edge.
//    A pending un-accepted request is retried after reset, starting from requester 0.
// TESTING
//  1. Reset: rst_i=1 mid-slot with en_o=32'h0000_00FF -> en_o=0, busy_o=0, owner_o=0 before next edge; q unchanged.
//  2. Single WRITE: req0 mask=32'h0000_FFFF, data=32'h1234_5678, q=0 -> ready0 at t;
//     en_o=32'h0000_FFFF, d_o=32'h1234_5678 at t+1; q=32'h0000_5678 at t+2.
//  3. Round-robin: all 4 valid continuously with SET ops -> grants 0,1,2,3,0 in consecutive cycles; owner_o follows one cycle later.
//  4. SET then CLR: q=0; SET mask 32'hF0 accepted at t, CLR mask 32'h30 at t+1 -> q=32'hC0 at t+3.
//  5. TOGGLE hazard: q=32'hA5; WRITE mask 32'hFF data 32'h0F at t, TOGGLE mask 32'h0F pending -> no ready at t+1;
//     TOGGLE accepted t+2 using q=32'h0F; final q=32'h00.
//  6. Zero mask: req2 mask=0 -> ready2 asserted, busy_o=1, en_o=0, q unchanged; rr_ptr advances to 3.

Source files
------------

// File: rtl/register_write_arbiter_if.sv
// Request/slot bus between requesters, the shared per-bit-enable register and the write arbiter.
// Port names keep the register-side _i/_o naming so both ends read the same.
interface register_write_arbiter_if #(
   parameter int N     = 4,
   parameter int IDX_W = 2
);
   logic [N-1:0]      req_valid_i;
   logic [2*N-1:0]    req_op_i;
   logic [32*N-1:0]   req_mask_i;
   logic [32*N-1:0]   req_data_i;
   logic [N-1:0]      req_ready_o;
   logic [31:0]       q_i;
   logic [31:0]       en_o;
   logic [31:0]       d_o;
   logic              busy_o;
   logic [IDX_W-1:0]  owner_o;

   modport master (
      output req_valid_i, req_op_i, req_mask_i, req_data_i, q_i,
      input  req_ready_o, en_o, d_o, busy_o, owner_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_mask_i, req_data_i, q_i,
      output req_ready_o, en_o, d_o, busy_o, owner_o
   );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin sequencer granting one masked op per cycle onto the shared 32-bit register.
// A TOGGLE must see settled q, so it waits one bubble behind any acceptance in the previous cycle.
module register_write_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   register_write_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_SET    = 2'b01,
      OP_CLR    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   logic [IDX_W-1:0] rr_ptr_r;
   logic             hazard_r;
   logic [31:0]      en_r;
   logic [31:0]      d_r;
   logic             busy_r;
   logic [IDX_W-1:0] owner_r;

   logic [IDX_W:0]   scan_idx_s;
   logic             cand_found_s;
   logic [IDX_W-1:0] cand_idx_s;
   op_e              cand_op_s;
   logic [31:0]      cand_mask_s;
   logic [31:0]      cand_data_s;
   logic             stall_s;
   logic             accept_s;
   logic [N-1:0]     ready_s;
   logic [31:0]      d_next_s;
   logic [IDX_W-1:0] ptr_next_s;

   // Candidate search: first valid requester at or after rr_ptr, wrapping modulo N
   always_comb begin
      cand_found_s = 1'b0;
      cand_idx_s   = '0;
      scan_idx_s   = '0;
      for (int i = 0; i < N; i++) begin
         scan_idx_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
         if (scan_idx_s >= (IDX_W+1)'(N)) begin
            scan_idx_s = scan_idx_s - (IDX_W+1)'(N);
         end else begin
            scan_idx_s = scan_idx_s;
         end
         if (!cand_found_s && bus.req_valid_i[scan_idx_s[IDX_W-1:0]]) begin
            cand_found_s = 1'b1;
            cand_idx_s   = scan_idx_s[IDX_W-1:0];
         end else begin
            cand_found_s = cand_found_s;
         end
      end
   end

   // Candidate decode, TOGGLE interlock, grant and next-slot data
   always_comb begin
      cand_op_s   = op_e'(bus.req_op_i[{cand_idx_s, 1'b0} +: 2]);
      cand_mask_s = bus.req_mask_i[{cand_idx_s, 5'd0} +: 32];
      cand_data_s = bus.req_data_i[{cand_idx_s, 5'd0} +: 32];
      stall_s     = 1'b0;
      ready_s     = '0;
      d_next_s    = 32'h0000_0000;
      ptr_next_s  = rr_ptr_r;

      if (hazard_r && (cand_op_s == OP_TOGGLE)) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end

      accept_s = cand_found_s && !stall_s && !rst_i;

      if (accept_s) begin
         ready_s[cand_idx_s] = 1'b1;
      end else begin
         ready_s = '0;
      end

      if (cand_idx_s == IDX_W'(N - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = cand_idx_s + IDX_W'(1);
      end

      // TOGGLE inverts the q seen now; the interlock guarantees it is current
      case (cand_op_s)
         OP_WRITE:  d_next_s = cand_data_s;
         OP_SET:    d_next_s = 32'hFFFF_FFFF;
         OP_CLR:    d_next_s = 32'h0000_0000;
         OP_TOGGLE: d_next_s = ~bus.q_i;
         default:   d_next_s = 32'h0000_0000;
      endcase
   end

   // Slot registers: one-cycle en pulse per acceptance; d/owner hold between slots
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_r <= '0;
         hazard_r <= 1'b0;
         en_r     <= 32'h0000_0000;
         d_r      <= 32'h0000_0000;
         busy_r   <= 1'b0;
         owner_r  <= '0;
      end else begin
         hazard_r <= accept_s;
         if (accept_s) begin
            rr_ptr_r <= ptr_next_s;
            en_r     <= cand_mask_s;
            d_r      <= d_next_s;
            busy_r   <= 1'b1;
            owner_r  <= cand_idx_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
            en_r     <= 32'h0000_0000;
            d_r      <= d_r;
            busy_r   <= 1'b0;
            owner_r  <= owner_r;
         end
      end
   end

   assign bus.req_ready_o = ready_s;
   assign bus.en_o        = en_r;
   assign bus.d_o         = d_r;
   assign bus.busy_o      = busy_r;
   assign bus.owner_o     = owner_r;

endmodule
